// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//   Packs a 32-bit two's-complement immediate into the scattered immediate
//   fields of an RV32I instruction word (I/U/S/B/J). All bits that are not part
//   of the selected immediate field are copied from a caller-supplied base
//   word. Immediates that the format cannot represent are flagged.
//
//   Two-stage elastic pipeline:
//     S1 captures the request and the encode/flag logic runs from the S1 flops.
//     S2 registers the result and drives every output directly from flops.
//   Latency is 2 cycles and throughput is 1 word per cycle.
//
// Parameters
//   CNT_W   width of the saturating error counter
//   STRICT  1: any flagged word is replaced by NOP (addi x0,x0,0) on output
//
// Ports
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   in_valid     request valid
//   in_ready     S1 can accept a request this cycle
//   extop        format select: 000 I, 001 U, 010 S, 011 B, 100 J, else illegal
//   imm          immediate value
//   base         instruction word supplying the non-immediate bits
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   instr        assembled instruction word
//   range_err    immediate does not fit the format
//   align_err    immediate has low bits set that the format drops
//   ext_err      illegal extop
//   clr_cnt      synchronous clear of err_cnt (wins over an increment)
//   err_cnt      saturating count of accepted results carrying any flag
// -----------------------------------------------------------------------------
module imm_encoder #(
    parameter int CNT_W  = 8,
    parameter bit STRICT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       extop,
    input  logic [31:0]      imm,
    input  logic [31:0]      base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             range_err,
    output logic             align_err,
    output logic             ext_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0]       EXT_I   = 3'b000;
    localparam logic [2:0]       EXT_U   = 3'b001;
    localparam logic [2:0]       EXT_S   = 3'b010;
    localparam logic [2:0]       EXT_B   = 3'b011;
    localparam logic [2:0]       EXT_J   = 3'b100;
    localparam logic [31:0]      NOP     = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ---------------------------------------------------------------- S1 state
    logic        r_s1_valid;
    logic [2:0]  r_s1_extop;
    logic [31:0] r_s1_imm;
    logic [31:0] r_s1_base;

    // ---------------------------------------------------------------- S2 state
    logic             r_s2_valid;
    logic [31:0]      r_instr;
    logic             r_range_err;
    logic             r_align_err;
    logic             r_ext_err;
    logic [CNT_W-1:0] r_err_cnt;

    // ---------------------------------------------------------------- control
    logic w_s2_load;
    logic w_in_hs;
    logic w_out_hs;

    // S2 takes the S1 word whenever it is empty or being drained this cycle,
    // so S1 can refill in the same cycle and the pipe runs bubble-free.
    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = r_s2_valid && out_ready;

    // ---------------------------------------------------------------- encode
    logic        w_fit12;   // imm[31:11] is a pure sign extension (I/S)
    logic        w_fit13;   // imm[31:12] is a pure sign extension (B)
    logic        w_fit21;   // imm[31:20] is a pure sign extension (J)
    logic [31:0] w_instr;
    logic        w_range_err;
    logic        w_align_err;
    logic        w_ext_err;
    logic        w_any_err;
    logic [31:0] w_out_word;

    assign w_fit12 = (&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]);
    assign w_fit13 = (&r_s1_imm[31:12]) || !(|r_s1_imm[31:12]);
    assign w_fit21 = (&r_s1_imm[31:20]) || !(|r_s1_imm[31:20]);

    always_comb begin
        w_instr     = r_s1_base;
        w_range_err = 1'b0;
        w_align_err = 1'b0;
        w_ext_err   = 1'b0;
        case (r_s1_extop)
            EXT_I: begin
                w_instr     = {r_s1_imm[11:0], r_s1_base[19:0]};
                w_range_err = !w_fit12;
            end
            EXT_U: begin
                // U has no range limit; only the dropped low 12 bits matter.
                w_instr     = {r_s1_imm[31:12], r_s1_base[11:0]};
                w_align_err = |r_s1_imm[11:0];
            end
            EXT_S: begin
                w_instr     = {r_s1_imm[11:5], r_s1_base[24:12],
                               r_s1_imm[4:0], r_s1_base[6:0]};
                w_range_err = !w_fit12;
            end
            EXT_B: begin
                w_instr     = {r_s1_imm[12], r_s1_imm[10:5], r_s1_base[24:12],
                               r_s1_imm[4:1], r_s1_imm[11], r_s1_base[6:0]};
                w_range_err = !w_fit13;
                w_align_err = r_s1_imm[0];
            end
            EXT_J: begin
                w_instr     = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                               r_s1_imm[19:12], r_s1_base[11:0]};
                w_range_err = !w_fit21;
                w_align_err = r_s1_imm[0];
            end
            default: begin
                // Illegal format: pass base through untouched.
                w_ext_err = 1'b1;
            end
        endcase
    end

    assign w_any_err  = w_range_err || w_align_err || w_ext_err;
    assign w_out_word = (STRICT && w_any_err) ? NOP : w_instr;

    // ---------------------------------------------------------------- S1 regs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_extop <= 3'b000;
            r_s1_imm   <= 32'h0;
            r_s1_base  <= 32'h0;
        end else begin
            if (w_in_hs) begin
                r_s1_valid <= 1'b1;
                r_s1_extop <= extop;
                r_s1_imm   <= imm;
                r_s1_base  <= base;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- S2 regs
    // Data flops only move on a load, so a stalled result stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_instr     <= 32'h0;
            r_range_err <= 1'b0;
            r_align_err <= 1'b0;
            r_ext_err   <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid  <= 1'b1;
                r_instr     <= w_out_word;
                r_range_err <= w_range_err;
                r_align_err <= w_align_err;
                r_ext_err   <= w_ext_err;
            end else if (out_ready) begin
                r_s2_valid  <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (clr_cnt) begin
            r_err_cnt <= '0;
        end else if (w_out_hs && (r_range_err || r_align_err || r_ext_err) &&
                     (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign out_valid = r_s2_valid;
    assign instr     = r_instr;
    assign range_err = r_range_err;
    assign align_err = r_align_err;
    assign ext_err   = r_ext_err;
    assign err_cnt   = r_err_cnt;

endmodule
